// File: rtl/fifo_pkg.sv
// Shared types for the FIFO push-side arbiter: beat layout, last-flag position, arbiter states.
package fifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int LAST_BIT   = DATA_WIDTH;

    typedef logic [DATA_WIDTH:0] beat_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester searching upward from last_owner+1.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     last_owner_i,
    output logic [IDW-1:0]     idx_o,
    output logic               any_valid_o
);

    localparam logic [IDW:0] LAST_IDX  = (IDW+1)'(NUM_REQ - 1);
    localparam logic [IDW:0] NUM_REQ_W = (IDW+1)'(NUM_REQ);

    logic [IDW:0]         start;
    logic [NUM_REQ-1:0]   rot;
    logic [IDW:0]         offs;
    logic [IDW:0]         sum;
    logic [IDW:0]         wrapped;
    logic                 found;

    // Rotating the doubled vector puts the search start at bit 0, so a plain
    // lowest-set-bit encoder gives the round-robin offset.
    always_comb begin
        start = ({1'b0, last_owner_i} >= LAST_IDX) ? '0 : ({1'b0, last_owner_i} + 1'b1);
        rot   = NUM_REQ'({req_i, req_i} >> start);
        offs  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                offs  = (IDW+1)'(i);
                found = 1'b1;
            end
        end
        sum         = start + offs;
        wrapped     = (sum >= NUM_REQ_W) ? (sum - NUM_REQ_W) : sum;
        idx_o       = wrapped[IDW-1:0];
        any_valid_o = found;
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NUM_REQ producers, locking
// the owner until a last-flagged beat or MAX_BURST beats have been pushed.
module fifo_push_arbiter
    import fifo_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int MAX_BURST = 16,
    localparam int IDW       = idx_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  beat_t [NUM_REQ-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]   req_grant_o,
    output logic                 push_valid_o,
    output beat_t                push_data_o,
    input  logic                 push_grant_i,
    output logic [IDW-1:0]       owner_o,
    output logic                 lock_o,
    output logic                 force_rel_o
);

    localparam logic [7:0]     BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic [IDW-1:0] LAST_REQ   = IDW'(NUM_REQ - 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] last_owner_q, last_owner_d;
    logic [7:0]     burst_cnt_q, burst_cnt_d;
    logic           force_rel_q, force_rel_d;

    logic [IDW-1:0] pick_idx;
    logic           any_valid;
    logic           sel_valid;
    beat_t          sel_data;
    logic           xfer;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .req_i        (req_valid_i),
        .last_owner_i (last_owner_q),
        .idx_o        (pick_idx),
        .any_valid_o  (any_valid)
    );

    assign sel_valid = req_valid_i[owner_q];
    assign sel_data  = req_data_i[owner_q];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        force_rel_d  = 1'b0;
        push_valid_o = 1'b0;
        push_data_o  = '0;
        req_grant_o  = '0;
        xfer         = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = LOCKED;
                end
            end
            LOCKED: begin
                push_valid_o         = sel_valid;
                push_data_o          = sel_data;
                xfer                 = sel_valid & push_grant_i;
                req_grant_o[owner_q] = xfer;
                if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                    // A last beat that also hits the burst limit is a normal release.
                    if (sel_data[LAST_BIT]) begin
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                    end else if (burst_cnt_q == BURST_LAST) begin
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                        force_rel_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_REQ;
            burst_cnt_q  <= '0;
            force_rel_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            force_rel_q  <= force_rel_d;
        end
    end

    assign owner_o     = owner_q;
    assign lock_o      = (state_q == LOCKED);
    assign force_rel_o = force_rel_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed and randomized bench for fifo_push_arbiter against a transaction-level requester/arbiter model.
module tb_fifo_push_arbiter;
    import fifo_pkg::*;

    localparam int N  = 4;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    beat_t [N-1:0]   req_data;
    logic [N-1:0]    req_grant;
    logic            push_valid;
    beat_t           push_data;
    logic            push_grant;
    logic [1:0]      owner;
    logic            lock;
    logic            force_rel;

    always #5 clk = ~clk;

    fifo_push_arbiter #(
        .NUM_REQ   (N),
        .MAX_BURST (MB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_grant_o  (req_grant),
        .push_valid_o (push_valid),
        .push_data_o  (push_data),
        .push_grant_i (push_grant),
        .owner_o      (owner),
        .lock_o       (lock),
        .force_rel_o  (force_rel)
    );

    int    checks = 0;
    int    errors = 0;
    beat_t q [N][$];
    bit    en [N];
    bit    rnd_mode;
    int    m_locked, m_owner, m_cnt, m_last, m_force;
    int    cyc;
    int    force_seen;
    int    lg_cyc[$];
    int    lg_data[$];
    int    lg_own[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_owner  = 0;
        m_cnt    = 0;
        m_last   = N - 1;
        m_force  = 0;
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg;
        beat_t        ed;
        logic         ev;
        ev = 1'b0;
        ed = '0;
        eg = '0;
        if (m_locked != 0) begin
            ev = req_valid[m_owner];
            ed = req_data[m_owner];
            if (push_grant && ev) eg[m_owner] = 1'b1;
        end
        chk("push_valid", 32'(push_valid), 32'(ev));
        chk("push_data",  32'(push_data),  32'(ed));
        chk("req_grant",  32'(req_grant),  32'(eg));
        chk("owner",      32'(owner),      32'(m_owner));
        chk("lock",       32'(lock),       32'(m_locked));
        chk("force_rel",  32'(force_rel),  32'(m_force));
    endtask

    // Called just after a falling edge: present requester beats, then sample.
    task automatic pre();
        for (int i = 0; i < N; i++) begin
            if (rnd_mode && !en[i] && ($urandom_range(1, 0) == 1)) en[i] = 1'b1;
            req_valid[i] = en[i] && (q[i].size() > 0);
            req_data[i]  = (q[i].size() > 0) ? q[i][0] : '0;
        end
        #1;
        check_outputs();
        if (push_valid === 1'b1 && push_grant === 1'b1) begin
            lg_cyc.push_back(cyc + 1);
            lg_data.push_back(int'(push_data));
            lg_own.push_back(int'(owner));
        end
        if (force_rel === 1'b1) force_seen++;
    endtask

    task automatic model_step();
        beat_t b;
        bit    found;
        int    idx;
        if (!rst_n) begin
            model_reset();
        end else if (m_locked == 0) begin
            m_force = 0;
            found   = 0;
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (!found && req_valid[idx]) begin
                    found    = 1;
                    m_owner  = idx;
                    m_cnt    = 0;
                    m_locked = 1;
                end
            end
        end else begin
            m_force = 0;
            if (req_valid[m_owner] && push_grant) begin
                b = q[m_owner].pop_front();
                if (rnd_mode) en[m_owner] = ($urandom_range(2, 0) != 0);
                m_cnt++;
                if (b[LAST_BIT]) begin
                    m_locked = 0;
                    m_last   = m_owner;
                end else if (m_cnt == MB) begin
                    m_locked = 0;
                    m_last   = m_owner;
                    m_force  = 1;
                end
            end
        end
    endtask

    task automatic post();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            pre();
            post();
        end
    endtask

    task automatic clear_log();
        lg_cyc.delete();
        lg_data.delete();
        lg_own.delete();
        cyc        = 0;
        force_seen = 0;
    endtask

    // Must follow pre(): drops rst_n mid-cycle and expects outputs clear before the next edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_push_valid", 32'(push_valid), 32'd0);
        chk("arst_push_data",  32'(push_data),  32'd0);
        chk("arst_grant",      32'(req_grant),  32'd0);
        chk("arst_owner",      32'(owner),      32'd0);
        chk("arst_lock",       32'(lock),       32'd0);
        chk("arst_force",      32'(force_rel),  32'd0);
        post();
        rst_n = 1'b1;
    endtask

    task automatic chk_log(input string tag, input int k, input int ec, input int ed, input int eo);
        chk({tag, "_cyc"},   32'(lg_cyc.size() > k ? lg_cyc[k] : -1),   32'(ec));
        chk({tag, "_data"},  32'(lg_data.size() > k ? lg_data[k] : -1), 32'(ed));
        chk({tag, "_owner"}, 32'(lg_own.size() > k ? lg_own[k] : -1),   32'(eo));
    endtask

    initial begin
        int len;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        push_grant = 1'b1;
        rnd_mode   = 1'b0;
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        model_reset();
        clear_log();
        @(negedge clk);

        // Reset hold with nothing requesting.
        run(10);
        chk("rst_hold_owner", 32'(owner), 32'd0);
        rst_n = 1'b1;

        // Two single-beat packets from req0 and req2.
        clear_log();
        q[0].push_back(9'h155);
        q[2].push_back(9'h1AA);
        run(5);
        chk("t2_count", 32'(lg_cyc.size()), 32'd2);
        chk_log("t2_b0", 0, 2, 'h155, 0);
        chk_log("t2_b1", 1, 4, 'h1AA, 2);

        // Three-beat packet from req1 with req3 waiting and a 5-cycle stall on beat 2.
        clear_log();
        q[1].push_back(9'h011);
        q[1].push_back(9'h022);
        q[1].push_back(9'h133);
        run(1);
        q[3].push_back(9'h1C3);
        run(1);
        push_grant = 1'b0;
        repeat (5) begin
            pre();
            chk("stall_data",  32'(push_data), 32'h022);
            chk("stall_grant", 32'(req_grant), 32'd0);
            chk("stall_lock",  32'(lock),      32'd1);
            post();
        end
        push_grant = 1'b1;
        run(4);
        chk("t3_count", 32'(lg_cyc.size()), 32'd4);
        chk_log("t3_b0", 0, 2,  'h011, 1);
        chk_log("t3_b1", 1, 8,  'h022, 1);
        chk_log("t3_b2", 2, 9,  'h133, 1);
        chk_log("t3_b3", 3, 11, 'h1C3, 3);

        // Forced release after MAX_BURST beats, req1 served, req0 resumes.
        clear_log();
        for (int k = 1; k <= 6; k++) q[0].push_back(beat_t'(k));
        q[1].push_back(9'h1B1);
        run(10);
        chk("t5_count", 32'(lg_cyc.size()), 32'd7);
        for (int k = 0; k < 4; k++) chk_log("t5_burst", k, 2 + k, k + 1, 0);
        chk_log("t5_req1", 4, 7,  'h1B1, 1);
        chk_log("t5_res5", 5, 9,  'h005, 0);
        chk_log("t5_res6", 6, 10, 'h006, 0);
        chk("t5_force_pulses", 32'(force_seen), 32'd1);
        pre();
        chk("hold_lock",  32'(lock),       32'd1);
        chk("hold_owner", 32'(owner),      32'd0);
        chk("hold_pv",    32'(push_valid), 32'd0);
        post();
        q[0].push_back(9'h107);
        run(2);

        // All requesters busy with single-beat packets; mid-stream reset restarts at 0.
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < N; i++) q[i].push_back(beat_t'({1'b1, 8'(i * 16 + k)}));
        pre();
        async_reset();
        clear_log();
        run(11);
        for (int k = 0; k < 5; k++) chk_log("rr_a", k, 2 + 2 * k, lg_data.size() > k ? lg_data[k] : -1, k % N);
        pre();
        chk("pre_rst_lock", 32'(lock), 32'd1);
        async_reset();
        clear_log();
        run(8);
        chk("rr_b_count", 32'(lg_cyc.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk("rr_b_owner", 32'(lg_own.size() > k ? lg_own[k] : -1), 32'(k));
        for (int k = 0; k < 4; k++) chk("rr_b_cyc", 32'(lg_cyc.size() > k ? lg_cyc[k] : -1), 32'(2 + 2 * k));

        // Randomized traffic: variable packet lengths, valid gaps, backpressure, resets.
        rnd_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (q[i].size() == 0 && $urandom_range(3, 0) == 0) begin
                    len = int'($urandom_range(7, 1));
                    for (int b = 0; b < len; b++)
                        q[i].push_back(beat_t'({(b == len - 1), 8'($urandom)}));
                end
            end
            push_grant = ($urandom_range(3, 0) != 0);
            pre();
            if (c % 1000 == 999) async_reset();
            else post();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
